mul_div_unit: RTL

Parametrised iterative multiply/divide unit. It is the successor to the team's fixed 32-bit separate multiplier and divider. A single shared datapath handles WIDTH-bit signed or unsigned multiply, and divide with remainder. It adds a start/done handshake, synchronous reset, divide-by-zero and signed-overflow handling, and a full 2·WIDTH product. It sits beside the correlator/accumulator datapath as the shared arithmetic resource.

---
 rtl/mul_div_pkg.sv | 9 +
 rtl/mul_div_abs.sv | 10 +
 rtl/mul_div_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared state encoding, opcodes and sizing helper for the multiply/divide unit
package mul_div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/mul_div_abs.sv
// mul_div_abs: conditional two's-complement negate, used for magnitudes and sign fix-up
module mul_div_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] res_o
);
   assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 signed/unsigned multiply and divide with start/done handshake
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             op_i,
   input  logic             sign_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic [WIDTH-1:0] result_lo_o,
   output logic             div_by_zero_o
);
   localparam int CW = cnt_width(WIDTH);
   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod;
   logic [WIDTH-1:0]   mcand_q, mcand_d, mag_a, mag_b, quot, rem;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               op_q, neg_q, rneg_q, dz_q, done_q, dbz_q, dbz_d;
   logic               accept, calc, fix, last, ge;
   logic [WIDTH:0]     sum, shifted;
   logic [WIDTH-1:0]   diff;

   assign accept = state_q == IDLE && start_i;
   assign calc   = state_q == CALC;
   assign fix    = state_q == FIX;
   assign last   = cnt_q == CW'(WIDTH - 1);

   mul_div_abs #(.WIDTH(WIDTH)) u_abs_a (
      .val_i(operand_a_i), .neg_i(sign_i & operand_a_i[WIDTH-1]), .res_o(mag_a));
   mul_div_abs #(.WIDTH(WIDTH)) u_abs_b (
      .val_i(operand_b_i), .neg_i(sign_i & operand_b_i[WIDTH-1]), .res_o(mag_b));
   mul_div_abs #(.WIDTH(2*WIDTH)) u_fix_p (
      .val_i(acc_q), .neg_i(neg_q), .res_o(prod));
   mul_div_abs #(.WIDTH(WIDTH)) u_fix_q (
      .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .res_o(quot));
   mul_div_abs #(.WIDTH(WIDTH)) u_fix_r (
      .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rneg_q), .res_o(rem));

   // Sequencing: accept in IDLE, WIDTH iteration cycles, one sign fix-up cycle.
   always_comb begin
      state_d = (state_q == IDLE) ? (start_i ? CALC : IDLE)
              : (state_q == CALC) ? (last ? FIX : CALC) : IDLE;
   end

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? mcand_q : {WIDTH{1'b0}}};
      shifted = acc_q[2*WIDTH-1:WIDTH-1];
      ge      = shifted >= {1'b0, mcand_q};
      diff    = shifted[WIDTH-1:0] - mcand_q;
      acc_d   = accept ? {{WIDTH{1'b0}}, op_i == OP_DIV ? mag_a : mag_b}
              : !calc ? acc_q
              : op_q == OP_DIV ? {ge ? diff : shifted[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
              : {sum, acc_q[WIDTH-1:1]};
      mcand_d = accept ? (op_i == OP_DIV ? mag_b : mag_a) : mcand_q;
      cnt_d   = accept ? '0 : calc ? cnt_q + CW'(1) : cnt_q;
   end

   // Result capture in the fix-up cycle; divide-by-zero flag clears on the next accept.
   always_comb begin
      hi_d  = fix ? (op_q == OP_DIV ? rem : prod[2*WIDTH-1:WIDTH]) : hi_q;
      lo_d  = fix ? (op_q == OP_DIV ? (dz_q ? {WIDTH{1'b1}} : quot) : prod[WIDTH-1:0]) : lo_q;
      dbz_d = fix ? dz_q : accept ? 1'b0 : dbz_q;
   end

   // Sequencer and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operation attributes captured once per accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_MUL;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else if (accept) begin
         op_q   <= op_i;
         neg_q  <= sign_i & (operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1]);
         rneg_q <= sign_i & operand_a_i[WIDTH-1];
         dz_q   <= op_i == OP_DIV && operand_b_i == '0;
      end
   end

   // Visible results, done pulse and divide-by-zero flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= fix;
         dbz_q  <= dbz_d;
      end
   end

   assign busy_o        = state_q != IDLE;
   assign done_o        = done_q;
   assign result_hi_o   = hi_q;
   assign result_lo_o   = lo_q;
   assign div_by_zero_o = dbz_q;
endmodule
